// File: rtl/iterative_divider_if.sv
// Request/result bundle between the execute stage and the iterative divider.
// The requester drives operands and the start strobe; the divider returns status and results.
interface iterative_divider_if #(
  parameter int WIDTH = 32
);
  logic             div;
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] y_in;
  logic             signed_op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient_out;
  logic [WIDTH-1:0] remainder_out;

  modport master (
    output div, x_in, y_in, signed_op,
    input  busy, done, quotient_out, remainder_out
  );

  modport slave (
    input  div, x_in, y_in, signed_op,
    output busy, done, quotient_out, remainder_out
  );
endinterface

// File: rtl/iterative_divider.sv
// Radix-2 restoring divider on operand magnitudes with a sign-fix step; quotient and
// remainder are both ready WIDTH+2 cycles after accept, requests outside IDLE are dropped.
module iterative_divider #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  iterative_divider_if.slave dif
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] x_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             dz_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] remo_q;

  logic [WIDTH:0]   trial;
  logic             take;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;
  logic [WIDTH-1:0] x_abs;
  logic [WIDTH-1:0] y_abs;

  // Partial remainder is always below the divisor, so the difference fits in WIDTH bits.
  always_comb begin
    trial = {rem_q, dvd_q[WIDTH-1]};
    take  = (trial >= {1'b0, dsr_q});
    rem_d = take ? (trial[WIDTH-1:0] - dsr_q) : trial[WIDTH-1:0];
    dvd_d = {dvd_q[WIDTH-2:0], take};
    x_abs = (dif.signed_op && dif.x_in[WIDTH-1]) ? (~dif.x_in + 1'b1) : dif.x_in;
    y_abs = (dif.signed_op && dif.y_in[WIDTH-1]) ? (~dif.y_in + 1'b1) : dif.y_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      x_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (dif.div) begin
            x_q     <= dif.x_in;
            dvd_q   <= x_abs;
            dsr_q   <= y_abs;
            rem_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= dif.signed_op & (dif.x_in[WIDTH-1] ^ dif.y_in[WIDTH-1]);
            rneg_q  <= dif.signed_op & dif.x_in[WIDTH-1];
            dz_q    <= (dif.y_in == '0);
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) state_q <= FIX;
        end
        FIX: begin
          // Divide-by-zero reports all-ones and hands back the untouched dividend.
          if (dz_q) begin
            quot_q <= '1;
            remo_q <= x_q;
          end else begin
            quot_q <= qneg_q ? (~dvd_q + 1'b1) : dvd_q;
            remo_q <= rneg_q ? (~rem_q + 1'b1) : rem_q;
          end
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dif.busy          = busy_q;
  assign dif.done          = done_q;
  assign dif.quotient_out  = quot_q;
  assign dif.remainder_out = remo_q;
endmodule

// File: tb/tb_iterative_divider.sv
// Directed-vector bench for iterative_divider: result values, fixed latency, busy/done
// shape, request hold-off, back-to-back accept and mid-operation reset.
module tb_iterative_divider;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  iterative_divider_if #(.WIDTH(32)) dif ();

  iterative_divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .dif   (dif)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                        output logic [31:0] q, output logic [31:0] r,
                        output int lat, output int bcnt, output logic pulse_ok);
    @(negedge clk);
    dif.div = 1'b1;
    dif.x_in = x;
    dif.y_in = y;
    dif.signed_op = s;
    @(posedge clk);
    #1;
    dif.div = 1'b0;
    dif.x_in = ~x;
    dif.y_in = 32'h5;
    dif.signed_op = ~s;
    lat = 0;
    bcnt = 0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (dif.busy) bcnt++;
      if (dif.done) break;
    end
    q = dif.quotient_out;
    r = dif.remainder_out;
    @(negedge clk);
    pulse_ok = !dif.done && !dif.busy;
  endtask

  initial begin
    logic [31:0] q, r;
    int lat, bcnt, n;
    logic ok, seen;

    vecs[0]  = '{32'd100,      32'd7,        1'b0, 32'h0000000E, 32'h00000002};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[2]  = '{32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'h00000001};
    vecs[3]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'h00000003, 32'hFFFFFFFF};
    vecs[4]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h00000000};
    vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000};
    vecs[6]  = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'h00000000};
    vecs[7]  = '{32'h12345678, 32'd0,        1'b0, 32'hFFFFFFFF, 32'h12345678};
    vecs[8]  = '{32'h12345678, 32'd0,        1'b1, 32'hFFFFFFFF, 32'h12345678};
    vecs[9]  = '{32'hFFFFFF9C, 32'd7,        1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE};
    vecs[10] = '{32'd0,        32'd5,        1'b1, 32'h00000000, 32'h00000000};
    vecs[11] = '{32'd1000,     32'd10,       1'b0, 32'd100,      32'd0};

    dif.div = 1'b0;
    dif.x_in = '0;
    dif.y_in = '0;
    dif.signed_op = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'b0, dif.busy}, 32'd0);
    chk("reset_done", {31'b0, dif.done}, 32'd0);
    chk("reset_q", dif.quotient_out, 32'd0);
    chk("reset_r", dif.remainder_out, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].x, vecs[i].y, vecs[i].s, q, r, lat, bcnt, ok);
      chk($sformatf("v%0d_q", i), q, vecs[i].q);
      chk($sformatf("v%0d_r", i), r, vecs[i].r);
      chk($sformatf("v%0d_latency", i), lat, 32'd34);
      chk($sformatf("v%0d_busy_cycles", i), bcnt, 32'd34);
      chk($sformatf("v%0d_done_one_cycle", i), {31'b0, ok}, 32'd1);
    end

    // Hold div high with wandering operands; only the first request and the one
    // presented when IDLE returns may be taken.
    @(negedge clk);
    dif.div = 1'b1;
    dif.x_in = 32'd100;
    dif.y_in = 32'd7;
    dif.signed_op = 1'b0;
    @(posedge clk);
    n = 0;
    seen = 1'b0;
    while (n < 60 && !seen) begin
      @(negedge clk);
      n++;
      if (dif.done) seen = 1'b1;
      else begin
        dif.x_in = $urandom;
        dif.y_in = $urandom_range(1, 1000);
        dif.signed_op = 1'($urandom_range(0, 1));
      end
    end
    chk("hold_first_latency", n, 32'd34);
    chk("hold_first_q", dif.quotient_out, 32'h0000000E);
    chk("hold_first_r", dif.remainder_out, 32'h00000002);
    dif.x_in = 32'd1000;
    dif.y_in = 32'd10;
    dif.signed_op = 1'b0;
    n = 0;
    seen = 1'b0;
    while (n < 80 && !seen) begin
      @(negedge clk);
      n++;
      if (dif.done) seen = 1'b1;
    end
    dif.div = 1'b0;
    chk("b2b_gap", n, 32'd35);
    chk("b2b_q", dif.quotient_out, 32'd100);
    chk("b2b_r", dif.remainder_out, 32'd0);
    repeat (2) @(negedge clk);
    chk("b2b_idle_after", {31'b0, dif.busy}, 32'd0);

    // Reset ten cycles into an operation abandons it with no done pulse.
    @(negedge clk);
    dif.div = 1'b1;
    dif.x_in = 32'h12345678;
    dif.y_in = 32'd3;
    dif.signed_op = 1'b0;
    @(posedge clk);
    #1;
    dif.div = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_busy", {31'b0, dif.busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", {31'b0, dif.busy}, 32'd0);
    chk("rst_mid_done", {31'b0, dif.done}, 32'd0);
    chk("rst_mid_q", dif.quotient_out, 32'd0);
    chk("rst_mid_r", dif.remainder_out, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (dif.done || dif.busy) seen = 1'b1;
    end
    chk("rst_no_done", {31'b0, seen}, 32'd0);
    run_op(32'd9, 32'd4, 1'b0, q, r, lat, bcnt, ok);
    chk("post_rst_q", q, 32'd2);
    chk("post_rst_r", r, 32'd1);
    chk("post_rst_latency", lat, 32'd34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/iterative_divider.md
Name: iterative_divider

Overview:
- Sequential 32-bit integer divider for the CPU execute stage; the division counterpart of the Booth/Wallace multiplier.
- Serves div.w/mod.w/div.wu/mod.wu and produces quotient and remainder together.
- Uses the same request/done handshake style as the multiplier, so the pipeline stall logic treats both units identically.
- Radix-2 restoring algorithm on magnitudes, followed by a sign-fix step.

Parameters:
- WIDTH, 32, operand/result width. Verification is only required at 32.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- div  input  1  start request; sampled only in IDLE.
- x_in  input  WIDTH  dividend; sampled on the accept edge.
- y_in  input  WIDTH  divisor; sampled on the accept edge.
- signed_op  input  1  1 = two's-complement operation, 0 = unsigned; sampled on the accept edge.
- busy  output  1  high from the cycle after accept through the DONE cycle.
- done  output  1  one-cycle pulse; results valid while high.
- quotient_out  output  WIDTH  quotient, held until the next accept.
- remainder_out  output  WIDTH  remainder, held until the next accept.

Behaviour:
- Reset (synchronous, any state): state=IDLE; busy=0, done=0, quotient_out=0, remainder_out=0; counter and datapath registers cleared. A reset mid-operation abandons the operation and no done pulse follows.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - On div=1 (accept edge E0), latch the operands, signed_op, the quotient sign (sx^sy) and the remainder sign (sx).
  - Also latch |x| and |y| when signed_op=1, raw values otherwise.
  - Also latch the divide-by-zero flag (y_in==0). Clear the partial remainder. Counter=0. Go to CALC.
- CALC: one restoring step per cycle.
  - Shift {rem,dvd} left by 1, giving a trial value of WIDTH+1 bits. Trial = rem - divisor.
  - If trial is non-negative: rem=trial and quotient bit=1; otherwise keep rem and quotient bit=0.
  - Counter increments. After WIDTH steps (edge E32), go to FIX.
- FIX (edge E33):
  - If signed_op=1: negate the quotient when the quotient sign is set, and negate the remainder when the remainder sign is set.
  - Divide-by-zero overrides everything: quotient_out=all ones, remainder_out=original x_in, in both modes.
  - Register the results and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: done is high in the cycle following edge E33, i.e. WIDTH+2 cycles after the accept edge. The latency is fixed, including divide-by-zero and zero dividend.
- Back-to-back: a div=1 seen in the cycle when state returns to IDLE is accepted. div=1 during CALC/FIX/DONE is ignored and never queued.
- Operand changes after E0 have no effect.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000, remainder=0. This falls out of the magnitude path and needs no special case.
- Sign rules: the quotient truncates toward zero; the remainder takes the dividend's sign; |remainder| < |divisor|.
- Outputs keep their last value between done pulses.

Test Plan:
- Unsigned 100/7 -> q=0x0000000E, r=0x00000002. done rises exactly 34 cycles after the accept edge and lasts 1 cycle. busy is high for 34 cycles.
- Signed -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7/-2 -> q=0xFFFFFFFD, r=0x00000001. Signed -7/-2 -> q=0x00000003, r=0xFFFFFFFF.
- Signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0. Unsigned with the same operands -> q=0, r=0x80000000. Unsigned 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
- Divide by zero: x=0x12345678, y=0 -> q=0xFFFFFFFF, r=0x12345678 with signed_op=0 and with signed_op=1. Latency is still 34 cycles.
- Hold div=1 with changing operands through a whole operation -> only the first operands are used. A second operation is accepted on the first IDLE cycle and completes correctly (1000/10 -> q=100, r=0).
- Assert reset 10 cycles after accept -> next cycle busy=0, done=0, outputs 0, and no done pulse follows. A fresh 9/4 then yields q=2, r=1.
